// File: rtl/bcd_digit_source.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Produces the four BCD digit nibbles and decimal-point mask for the
// seven-segment display controller and holds them stable between results.
module bcd_digit_source #(
  parameter int IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] value,
  input  logic [3:0]          dp_in,
  output logic                busy,
  output logic                done,
  output logic [15:0]         digits,
  output logic [3:0]          decimal_points,
  output logic                overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value that fits in four decimal digits.
  localparam logic [IN_WIDTH-1:0] MAX_VALUE  = IN_WIDTH'(9999);
  // Counter value on the last shift of a conversion.
  localparam logic [4:0]          LAST_COUNT = 5'(IN_WIDTH - 1);

  state_t              state_r;
  logic [IN_WIDTH-1:0] value_r;
  logic [15:0]         scratch_r;
  logic [3:0]          dp_r;
  logic [4:0]          count_r;
  logic                busy_r;
  logic                done_r;
  logic [15:0]         digits_r;
  logic [3:0]          decimal_points_r;
  logic                overflow_r;

  logic [15:0]         adjusted_s;
  logic [15:0]         shifted_s;

  // Add 3 to every nibble that is 5 or more; nibbles never carry into each other.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] bcd);
    logic [15:0] result;
    result = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        result[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        result[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return result;
  endfunction

  // Next scratch value: adjust nibbles, then shift in the current value MSB.
  always_comb begin
    adjusted_s = add3_nibbles(scratch_r);
    shifted_s  = {adjusted_s[14:0], value_r[IN_WIDTH-1]};
  end

  // Conversion FSM with registered outputs; results update only with a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      value_r          <= '0;
      scratch_r        <= 16'h0000;
      dp_r             <= 4'b0000;
      count_r          <= 5'd0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      digits_r         <= 16'h0000;
      decimal_points_r <= 4'b0000;
      overflow_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (value > MAX_VALUE) begin
              // Out-of-range values complete immediately with an error pattern.
              digits_r         <= 16'hEEEE;
              decimal_points_r <= 4'b1111;
              overflow_r       <= 1'b1;
              done_r           <= 1'b1;
            end else begin
              value_r   <= value;
              dp_r      <= dp_in;
              scratch_r <= 16'h0000;
              count_r   <= 5'd0;
              busy_r    <= 1'b1;
              state_r   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          scratch_r <= shifted_s;
          value_r   <= value_r << 1;
          count_r   <= count_r + 5'd1;
          if (count_r == LAST_COUNT) begin
            digits_r         <= shifted_s;
            decimal_points_r <= dp_r;
            overflow_r       <= 1'b0;
            done_r           <= 1'b1;
            busy_r           <= 1'b0;
            state_r          <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign digits         = digits_r;
  assign decimal_points = decimal_points_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_bcd_digit_source.sv
// Directed testbench for bcd_digit_source (IN_WIDTH = 14).
module tb_bcd_digit_source;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] value;
  logic [3:0]  dp_in;
  logic        busy;
  logic        done;
  logic [15:0] digits;
  logic [3:0]  decimal_points;
  logic        overflow;

  int          tests;
  int          failed;
  logic [15:0] last_digits;

  bcd_digit_source #(.IN_WIDTH(14)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .value          (value),
    .dp_in          (dp_in),
    .busy           (busy),
    .done           (done),
    .digits         (digits),
    .decimal_points (decimal_points),
    .overflow       (overflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference BCD of a decimal value 0..9999.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Called right after the accepting edge: checks 13 busy cycles, then the done cycle.
  task automatic finish_conv(input logic [15:0] exp_d, input logic [3:0] exp_dp);
    check("busy_rise", {15'd0, busy}, 16'd1);
    for (int i = 1; i < 14; i++) begin
      step();
      check("busy_hold", {15'd0, busy}, 16'd1);
      check("done_early", {15'd0, done}, 16'd0);
      check("digits_hold", digits, last_digits);
    end
    step();
    check("done_pulse", {15'd0, done}, 16'd1);
    check("busy_fall", {15'd0, busy}, 16'd0);
    check("digits", digits, exp_d);
    check("dp", {12'd0, decimal_points}, {12'd0, exp_dp});
    check("ovf_clear", {15'd0, overflow}, 16'd0);
    last_digits = exp_d;
  endtask

  task automatic convert(input int v, input logic [3:0] dp);
    value = 14'(v);
    dp_in = dp;
    start = 1'b1;
    step();
    start = 1'b0;
    finish_conv(to_bcd(v), dp);
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    last_digits = 16'h0000;
    rst_n       = 1'b0;
    start       = 1'b0;
    value       = 14'd0;
    dp_in       = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);
    check("rst_digits", digits, 16'h0000);
    check("rst_dp", {12'd0, decimal_points}, 16'd0);

    // Zero and a typical value.
    convert(0, 4'b0000);
    step();
    check("done_one_cycle", {15'd0, done}, 16'd0);
    convert(1234, 4'b0100);
    check("digits_1234", digits, 16'h1234);
    step();
    check("done_one_cycle2", {15'd0, done}, 16'd0);
    check("digits_hold_1234", digits, 16'h1234);

    // 9999 followed back-to-back by an overflow start in the done cycle.
    convert(9999, 4'b0001);
    value = 14'd10000;
    dp_in = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ovf_done", {15'd0, done}, 16'd1);
    check("ovf_digits", digits, 16'hEEEE);
    check("ovf_dp", {12'd0, decimal_points}, 16'h000F);
    check("ovf_flag", {15'd0, overflow}, 16'd1);
    check("ovf_busy", {15'd0, busy}, 16'd0);
    step();
    check("ovf_done_clear", {15'd0, done}, 16'd0);
    check("ovf_busy2", {15'd0, busy}, 16'd0);
    check("ovf_hold", digits, 16'hEEEE);
    last_digits = 16'hEEEE;

    // Maximum input is also an overflow.
    value = 14'd16383;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ovf_max_done", {15'd0, done}, 16'd1);
    check("ovf_max_flag", {15'd0, overflow}, 16'd1);
    check("ovf_max_busy", {15'd0, busy}, 16'd0);

    // start held high, value toggling during SHIFT.
    value = 14'd42;
    dp_in = 4'b0010;
    start = 1'b1;
    step();
    check("held_busy", {15'd0, busy}, 16'd1);
    for (int i = 1; i < 14; i++) begin
      value = (i % 2 == 1) ? 14'd77 : 14'd42;
      dp_in = 4'b1000;
      step();
      check("held_busy_hold", {15'd0, busy}, 16'd1);
      check("held_digits_hold", digits, 16'hEEEE);
    end
    value = 14'd77;
    dp_in = 4'b1000;
    step();
    check("held_done", {15'd0, done}, 16'd1);
    check("held_digits_42", digits, 16'h0042);
    check("held_dp", {12'd0, decimal_points}, 16'h0002);
    check("held_ovf", {15'd0, overflow}, 16'd0);
    last_digits = 16'h0042;
    step();
    start = 1'b0;
    finish_conv(16'h0077, 4'b1000);

    // Reset in the middle of a conversion of 5678.
    value = 14'd5678;
    dp_in = 4'b0101;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_digits", digits, 16'h0000);
    check("abort_dp", {12'd0, decimal_points}, 16'd0);
    last_digits = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      step();
      check("abort_no_done", {15'd0, done}, 16'd0);
    end
    convert(5678, 4'b0101);

    // Sampled sweep with the upper boundary.
    for (int v = 0; v <= 9999; v += 97) begin
      convert(v, 4'(v));
    end
    convert(9999, 4'b1010);
    convert(1000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
